// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the LCD write sequencer: state encodings, LCD command
// constants and the power-on init nibble/wait list.
package lcd_write_sequencer_pkg;

  localparam int unsigned COUNT_W = 20;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_STROBE,
    INIT_CMD,
    IDLE,
    HI_NIB,
    GAP,
    LO_NIB,
    WAIT
  } seqState_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } strobePhase_t;

  localparam logic [7:0] LCD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_HOME         = 8'h02;
  localparam logic [7:0] LCD_HOME_ALT     = 8'h03;
  localparam logic [7:0] LCD_FUNCTION_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] LCD_DISPLAY_ON   = 8'h0C;

  // Single-nibble wake-up strobes issued before the interface is in 4-bit mode.
  function automatic logic [3:0] initNibble(input logic [1:0] idx);
    case (idx)
      2'd3:    return 4'h2;
      default: return 4'h3;
    endcase
  endfunction

  function automatic logic [COUNT_W-1:0] initWait(input logic [1:0] idx);
    case (idx)
      2'd0:    return COUNT_W'(205000);
      2'd1:    return COUNT_W'(5000);
      default: return COUNT_W'(2000);
    endcase
  endfunction

  function automatic logic [7:0] initByte(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNCTION_SET;
      2'd1:    return LCD_ENTRY_MODE;
      2'd2:    return LCD_DISPLAY_ON;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Clear and return-home need the long execution wait.
  function automatic logic isLongCommand(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == LCD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One-nibble strobe generator: drives the nibble, waits SETUP, raises E for
// PULSE, holds for HOLD, then flags done. Times itself with the parent's counter.
module lcd_nibble_strobe
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES  = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [3:0]         iNibble,
  input  logic               iCountZero,
  output logic               oLoad_c,
  output logic [COUNT_W-1:0] oLoadValue_c,
  output logic               oDone_c,
  output logic               oEnabled,
  output logic [3:0]         oData
);

  strobePhase_t phase;

  // Counter reload requests at each phase boundary; done is seen in the last HOLD cycle.
  always_comb begin
    oLoad_c      = 1'b0;
    oLoadValue_c = '0;
    oDone_c      = 1'b0;
    if (iStart) begin
      oLoad_c      = 1'b1;
      oLoadValue_c = COUNT_W'(SETUP_CYCLES - 1);
    end else if (iCountZero) begin
      case (phase)
        PH_SETUP: begin
          oLoad_c      = 1'b1;
          oLoadValue_c = COUNT_W'(PULSE_CYCLES - 1);
        end
        PH_PULSE: begin
          oLoad_c      = 1'b1;
          oLoadValue_c = COUNT_W'(HOLD_CYCLES - 1);
        end
        PH_HOLD:  oDone_c = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase    <= PH_IDLE;
      oEnabled <= 1'b0;
      oData    <= '0;
    end else if (iStart) begin
      phase    <= PH_SETUP;
      oEnabled <= 1'b0;
      oData    <= iNibble;
    end else if (iCountZero) begin
      case (phase)
        PH_SETUP: begin
          phase    <= PH_PULSE;
          oEnabled <= 1'b1;
        end
        PH_PULSE: begin
          phase    <= PH_HOLD;
          oEnabled <= 1'b0;
        end
        PH_HOLD:  phase <= PH_IDLE;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Serialises byte writes onto the 4-bit character LCD bus with strobe and
// command timing. Define LCD_POWERON_INIT_EN to run the power-on init sequence.
module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES        = 2,
  parameter int unsigned PULSE_CYCLES        = 12,
  parameter int unsigned HOLD_CYCLES         = 1,
  parameter int unsigned NIBBLE_GAP_CYCLES   = 50,
  parameter int unsigned CMD_WAIT_CYCLES     = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES   = 82000,
  parameter int unsigned POWERON_WAIT_CYCLES = 750000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRequest,
  input  logic       iRegisterSelect,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  seqState_t          state;
  logic [COUNT_W-1:0] count;
  logic               countZero;
  logic [7:0]         byteReg;
  logic               accept;
  logic               strobeStart;
  logic [3:0]         strobeNibble;
  logic               strobeLoad_c;
  logic [COUNT_W-1:0] strobeLoadValue_c;
  logic               strobeDone_c;
`ifdef LCD_POWERON_INIT_EN
  logic [1:0]         initIdx;
  logic [1:0]         byteIdx;
  logic [7:0]         nextByte;
`endif

  assign countZero               = (count == '0);
  assign accept                  = (state == IDLE) && oReady && iRequest;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  lcd_nibble_strobe #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .PULSE_CYCLES (PULSE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) uStrobe (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (strobeStart),
    .iNibble      (strobeNibble),
    .iCountZero   (countZero),
    .oLoad_c      (strobeLoad_c),
    .oLoadValue_c (strobeLoadValue_c),
    .oDone_c      (strobeDone_c),
    .oEnabled     (oLCD_Enabled),
    .oData        (oLCD_Data)
  );

  // Strobe launch: on the same edge the FSM enters a nibble state.
  always_comb begin
    strobeStart  = 1'b0;
    strobeNibble = byteReg[3:0];
`ifdef LCD_POWERON_INIT_EN
    nextByte     = initByte(2'd0);
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          strobeStart  = 1'b1;
          strobeNibble = iData[7:4];
        end
      end
      GAP: begin
        if (countZero) strobeStart = 1'b1;
      end
`ifdef LCD_POWERON_INIT_EN
      INIT_WAIT: begin
        if (countZero) begin
          strobeStart  = 1'b1;
          strobeNibble = initNibble(initIdx);
        end
      end
      INIT_CMD: begin
        if (countZero) begin
          strobeStart = 1'b1;
          if (initIdx != 2'd3) strobeNibble = initNibble(initIdx + 2'd1);
          else                 strobeNibble = nextByte[7:4];
        end
      end
      WAIT: begin
        if (countZero && !oInitDone && byteIdx != 2'd3) begin
          nextByte     = initByte(byteIdx + 2'd1);
          strobeStart  = 1'b1;
          strobeNibble = nextByte[7:4];
        end
      end
`endif
      default: ;
    endcase
  end

  // Sequencer FSM and the shared down-counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
`ifdef LCD_POWERON_INIT_EN
      state               <= INIT_WAIT;
      initIdx             <= 2'd0;
      byteIdx             <= 2'd0;
`else
      state               <= IDLE;
`endif
      // Without init the counter just runs out unobserved in IDLE.
      count               <= COUNT_W'(POWERON_WAIT_CYCLES - 1);
      byteReg             <= '0;
      oReady              <= 1'b0;
      oInitDone           <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
    end else begin
      if (strobeLoad_c)    count <= strobeLoadValue_c;
      else if (!countZero) count <= count - COUNT_W'(1);

      case (state)
        IDLE: begin
          oReady    <= ~accept;
          oInitDone <= 1'b1;
          if (accept) begin
            byteReg             <= iData;
            oLCD_RegisterSelect <= iRegisterSelect;
            state               <= HI_NIB;
          end
        end
        HI_NIB: begin
          if (strobeDone_c) begin
            state <= GAP;
            count <= COUNT_W'(NIBBLE_GAP_CYCLES - 1);
          end
        end
        GAP: begin
          if (countZero) state <= LO_NIB;
        end
        LO_NIB: begin
          if (strobeDone_c) begin
            state <= WAIT;
            count <= isLongCommand(oLCD_RegisterSelect, byteReg)
                     ? COUNT_W'(CLEAR_WAIT_CYCLES - 1)
                     : COUNT_W'(CMD_WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (countZero) begin
`ifdef LCD_POWERON_INIT_EN
            if (!oInitDone && byteIdx != 2'd3) begin
              byteIdx <= byteIdx + 2'd1;
              byteReg <= initByte(byteIdx + 2'd1);
              state   <= HI_NIB;
            end else begin
              state     <= IDLE;
              oReady    <= 1'b1;
              oInitDone <= 1'b1;
            end
`else
            state  <= IDLE;
            oReady <= 1'b1;
`endif
          end
        end
`ifdef LCD_POWERON_INIT_EN
        INIT_WAIT: begin
          if (countZero) state <= INIT_STROBE;
        end
        INIT_STROBE: begin
          if (strobeDone_c) begin
            state <= INIT_CMD;
            count <= initWait(initIdx) - COUNT_W'(1);
          end
        end
        INIT_CMD: begin
          if (countZero) begin
            if (initIdx != 2'd3) begin
              initIdx <= initIdx + 2'd1;
              state   <= INIT_STROBE;
            end else begin
              byteIdx <= 2'd0;
              byteReg <= initByte(2'd0);
              state   <= HI_NIB;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
